multi_channel_debouncer: RTL and testbench
==========================================

MULTI_CHANNEL_DEBOUNCER -- requirements
Module: multi_channel_debouncer

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, number of independent button channels (1..32).
REQ-002 The block SHALL have parameter DELAY_CYCLES, default 2000000, consecutive stable synchronized samples needed to accept a level change (>=1).
REQ-003 The block SHALL have parameter LONG_CYCLES, default 50000000, cycles a press is held before the long-press event fires (>DELAY_CYCLES).
REQ-004 The block SHALL have parameter BTN_ACTIVE_LOW, default 0; when 1 each btn_i bit is inverted before synchronization.
REQ-005 The block SHALL have port clk_i, input, 1 bit: single clock, all state on rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port btn_i, input, N_CH bits: raw asynchronous bouncing buttons, bit n = channel n.
REQ-008 The block SHALL have port level_o, output, N_CH bits: debounced pressed level per channel.
REQ-009 The block SHALL have port press_o, output, N_CH bits: one-cycle pulse on accepted press.
REQ-010 The block SHALL have port release_o, output, N_CH bits: one-cycle pulse on accepted release.
REQ-011 The block SHALL have port long_o, output, N_CH bits: one-cycle pulse on long press.

Function
REQ-012 Each channel SHALL pass its (polarity-corrected) input through a 2-flop synchronizer; the second flop output is the sample used by that channel's FSM.
REQ-013 Each channel SHALL run an independent FSM with states LOW, RISE_WAIT, HIGH, FALL_WAIT and a stability counter of width $clog2(DELAY_CYCLES+1).
REQ-014 LOW: sample 1 -> RISE_WAIT, counter cleared to 0; sample 0 -> stay.
REQ-015 RISE_WAIT: sample 0 -> LOW with no output change; sample 1 and counter == DELAY_CYCLES-1 -> HIGH; otherwise counter +1.
REQ-016 HIGH: sample 0 -> FALL_WAIT, counter cleared; sample 1 -> stay.
REQ-017 FALL_WAIT: sample 1 -> HIGH with no output change; sample 0 and counter == DELAY_CYCLES-1 -> LOW; otherwise counter +1.
REQ-018 level_o[n] SHALL be registered and equal 1 exactly while channel n is in HIGH or FALL_WAIT.
REQ-019 press_o[n] SHALL be high for exactly the one cycle after the RISE_WAIT->HIGH transition; release_o[n] likewise after FALL_WAIT->LOW.
REQ-020 Latency: btn_i stable active from before edge k SHALL give level_o and press_o high after edge k+DELAY_CYCLES+2; release symmetric.
REQ-021 Any bounce inside RISE_WAIT or FALL_WAIT SHALL abort the wait; the counter restarts from 0 on the next qualifying edge.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-023 press_o and release_o of one channel SHALL never be high in the same cycle.

Reset
REQ-024 rst_i high SHALL asynchronously force all FSMs to LOW, all counters and synchronizer flops to the inactive value 0, and level_o, press_o, release_o, long_o to 0.
REQ-025 Reset asserted while a channel is HIGH SHALL NOT generate a release_o pulse; after deassertion a held button SHALL be re-debounced as a new press (full REQ-020 latency).

Configuration
REQ-026 Macro DEBOUNCE_LONG_PRESS_EN defined: each channel SHALL have a hold counter of width $clog2(LONG_CYCLES+1), cleared on entering RISE_WAIT->HIGH, incrementing in HIGH and FALL_WAIT, saturating.
REQ-027 With DEBOUNCE_LONG_PRESS_EN, long_o[n] SHALL pulse once for one cycle when the hold counter reaches LONG_CYCLES-1, i.e. LONG_CYCLES cycles after press_o[n]; at most one pulse per press; the hold counter clears on reaching LOW.
REQ-028 Without DEBOUNCE_LONG_PRESS_EN, no hold counters SHALL be instantiated and long_o SHALL be constant 0.

Verification (N_CH=2, DELAY_CYCLES=8, LONG_CYCLES=32, BTN_ACTIVE_LOW=0)
REQ-029 Clean press: btn_i[0] 0->1 before edge 0, held -> level_o[0]=1 and press_o[0] one-cycle pulse after edge 10; channel 1 outputs stay 0.
REQ-030 Bounce: btn_i[0] toggles every 3 cycles for 30 cycles, then stays high -> no press_o during toggling; press_o after edge (last rise)+10.
REQ-031 Release with glitch: from HIGH, btn_i[0]=0 for 5 cycles, 1 for 1 cycle, then 0 -> level_o stays 1 through glitch; release_o pulses once, 10 edges after final fall.
REQ-032 Simultaneous: both channels rise on the same edge -> press_o=2'b11 in a single cycle.
REQ-033 Long press (macro on): held 60 cycles -> long_o[0] single pulse 32 cycles after press_o[0]; none on 20-cycle press; macro off -> long_o always 0.
REQ-034 Reset mid-press: rst_i pulsed while level_o[0]=1 and button held -> level_o=0 immediately, no release_o; press_o re-fires 10 edges after rst_i deasserts.

Source files
------------

// File: rtl/multi_channel_debouncer.sv
// multi_channel_debouncer: N_CH independent button debouncers.
// Each raw input is polarity-corrected and passed through a 2-flop
// synchronizer. It then drives a LOW/RISE_WAIT/HIGH/FALL_WAIT FSM that
// accepts a level change only after DELAY_CYCLES consecutive stable samples.
//
// Optional feature: define DEBOUNCE_LONG_PRESS_EN to enable per-channel hold
// counters and the long_o event. Without it, long_o is constant 0.
//
// Ports:
//   clk_i     - clock; all state changes on the rising edge
//   rst_i     - asynchronous active-high reset
//   btn_i     - raw bouncing buttons, bit n = channel n
//   level_o   - registered debounced pressed level per channel
//   press_o   - one-cycle pulse on an accepted press
//   release_o - one-cycle pulse on an accepted release
//   long_o    - one-cycle pulse LONG_CYCLES cycles after press_o (feature only)
module multi_channel_debouncer #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned DELAY_CYCLES   = 2000000,
    parameter int unsigned LONG_CYCLES    = 50000000,
    parameter int unsigned BTN_ACTIVE_LOW = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o
);

    localparam int unsigned CNT_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    // Reject parameter sets that leave the event timing ill-defined.
    if (N_CH < 1 || N_CH > 32 || DELAY_CYCLES < 1 || LONG_CYCLES <= DELAY_CYCLES) begin : g_bad_params
        $error("multi_channel_debouncer: illegal parameter combination");
    end

    // Two-flop synchronizer, reset to the inactive (not pressed) value.
    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = (BTN_ACTIVE_LOW != 0) ? ~btn_i : btn_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             sample;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;

        assign sample = sync2_q[ch];

        // State and stability counter register.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_LOW;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next-state and stability counter logic.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                ST_LOW: begin
                    if (sample) begin
                        state_d = ST_RISE_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_RISE_WAIT: begin
                    if (!sample) begin
                        state_d = ST_LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HIGH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!sample) begin
                        state_d = ST_FALL_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_FALL_WAIT: begin
                    if (sample) begin
                        state_d = ST_HIGH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the upcoming state so the registered
        // level and pulses line up with the state register.
        always_comb begin
            level_d   = (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
            press_d   = (state_q == ST_RISE_WAIT) && (state_d == ST_HIGH);
            release_d = (state_q == ST_FALL_WAIT) && (state_d == ST_LOW);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign level_o[ch]   = level_q;
        assign press_o[ch]   = press_q;
        assign release_o[ch] = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
        localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
        localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              long_q, long_d;
        logic              held;

        assign held = (state_q == ST_HIGH) || (state_q == ST_FALL_WAIT);

        // Hold counter: restarts on an accepted press and saturates one past
        // the firing value so long_o fires only once per press.
        always_comb begin
            hold_d = hold_q;
            long_d = held && (hold_q == HOLD_LAST);
            if ((state_q == ST_RISE_WAIT) && (state_d == ST_HIGH)) begin
                hold_d = '0;
            end else if (state_d == ST_LOW) begin
                hold_d = '0;
            end else if (held && (hold_q != HOLD_MAX)) begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign long_o[ch] = long_q;
`else
        assign long_o[ch] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Directed bench for multi_channel_debouncer (N_CH=2, DELAY=8, LONG=32).
module tb_multi_channel_debouncer;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned DELAY = 8;
    localparam int unsigned LONG  = 32;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int EXP_LONG_CNT = 1;
    localparam int EXP_LONG_IDX = 10 + 32;
`else
    localparam int EXP_LONG_CNT = 0;
    localparam int EXP_LONG_IDX = -1;
`endif

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] long_p;

    int checks = 0;
    int errors = 0;

    multi_channel_debouncer #(
        .N_CH           (N_CH),
        .DELAY_CYCLES   (DELAY),
        .LONG_CYCLES    (LONG),
        .BTN_ACTIVE_LOW (0)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .btn_i     (btn),
        .level_o   (level),
        .press_o   (press),
        .release_o (rel),
        .long_o    (long_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  btn;
        int unsigned cycles;
        logic [1:0]  level;
        logic [1:0]  press;
        logic [1:0]  rel;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit later.
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor state for the multi-cycle sequences.
    int press_cnt, press_idx, rel_cnt, rel_idx, long_cnt, long_idx, overlap_cnt;

    task automatic mon_clear();
        press_cnt = 0; press_idx = -1;
        rel_cnt = 0; rel_idx = -1;
        long_cnt = 0; long_idx = -1;
        overlap_cnt = 0;
    endtask

    task automatic mon_sample(input int idx);
        if (press[0]) begin press_cnt++; press_idx = idx; end
        if (rel[0])   begin rel_cnt++;   rel_idx = idx;   end
        if (long_p[0]) begin long_cnt++; long_idx = idx; end
        if ((press & rel) != 2'b00) overlap_cnt++;
    endtask

    initial begin
        // btn, cycles, level, press, release  (expectations after the last edge)
        vecs[0]  = '{2'b00,  3, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{2'b01, 10, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{2'b01,  1, 2'b01, 2'b01, 2'b00};
        vecs[3]  = '{2'b01,  1, 2'b01, 2'b00, 2'b00};
        vecs[4]  = '{2'b01,  5, 2'b01, 2'b00, 2'b00};
        vecs[5]  = '{2'b00, 10, 2'b01, 2'b00, 2'b00};
        vecs[6]  = '{2'b00,  1, 2'b00, 2'b00, 2'b01};
        vecs[7]  = '{2'b00,  1, 2'b00, 2'b00, 2'b00};
        vecs[8]  = '{2'b11, 10, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{2'b11,  1, 2'b11, 2'b11, 2'b00};
        vecs[10] = '{2'b11,  1, 2'b11, 2'b00, 2'b00};
        vecs[11] = '{2'b01, 11, 2'b01, 2'b00, 2'b10};
        vecs[12] = '{2'b00, 11, 2'b00, 2'b00, 2'b01};
        vecs[13] = '{2'b00,  2, 2'b00, 2'b00, 2'b00};

        rst = 1'b1;
        btn = '0;
        step(2);
        check("reset_level",   int'(level),  0);
        check("reset_press",   int'(press),  0);
        check("reset_release", int'(rel),    0);
        check("reset_long",    int'(long_p), 0);
        rst = 1'b0;

        // Table: clean press/release, simultaneous press, independent release.
        for (int i = 0; i < 14; i++) begin
            btn = vecs[i].btn;
            step(vecs[i].cycles);
            check($sformatf("vec%0d_level", i),   int'(level),  int'(vecs[i].level));
            check($sformatf("vec%0d_press", i),   int'(press),  int'(vecs[i].press));
            check($sformatf("vec%0d_release", i), int'(rel),    int'(vecs[i].rel));
            check($sformatf("vec%0d_long", i),    int'(long_p), 0);
        end

        // Bounce: toggle every 3 cycles for 30 cycles, then hold high.
        mon_clear();
        for (int c = 0; c < 60; c++) begin
            btn[0] = (c >= 30) ? 1'b1 : (((c / 3) % 2) == 0);
            step(1);
            mon_sample(c);
        end
        check("bounce_press_cnt", press_cnt, 1);
        check("bounce_press_idx", press_idx, 40);
        check("bounce_level", int'(level), 1);

        // Release with a one-cycle glitch back high.
        mon_clear();
        for (int c = 0; c < 30; c++) begin
            btn[0] = (c == 5);
            step(1);
            mon_sample(c);
            if (c == 15) check("glitch_level_held", int'(level[0]), 1);
        end
        check("glitch_release_cnt", rel_cnt, 1);
        check("glitch_release_idx", rel_idx, 16);
        check("glitch_level_low", int'(level[0]), 0);

        // Long press: held 60 cycles.
        mon_clear();
        for (int c = 0; c < 90; c++) begin
            btn[0] = (c < 60);
            step(1);
            mon_sample(c);
        end
        check("long_press_idx", press_idx, 10);
        check("long_cnt", long_cnt, EXP_LONG_CNT);
        check("long_idx", long_idx, EXP_LONG_IDX);
        check("long_release_idx", rel_idx, 70);
        check("long_overlap", overlap_cnt, 0);

        // Short press: 20 cycles, no long event.
        mon_clear();
        for (int c = 0; c < 45; c++) begin
            btn[0] = (c < 20);
            step(1);
            mon_sample(c);
        end
        check("short_press_cnt", press_cnt, 1);
        check("short_release_idx", rel_idx, 30);
        check("short_long_cnt", long_cnt, 0);

        // Reset while pressed and held.
        btn[0] = 1'b1;
        step(15);
        check("rstmid_level_before", int'(level[0]), 1);
        rst = 1'b1;
        #1;
        check("rstmid_level_async", int'(level), 0);
        check("rstmid_release_async", int'(rel), 0);
        mon_clear();
        step(2);
        mon_sample(-1);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            mon_sample(c);
        end
        check("rstmid_release_cnt", rel_cnt, 0);
        check("rstmid_press_cnt", press_cnt, 1);
        check("rstmid_press_idx", press_idx, 10);
        check("rstmid_ch1_level", int'(level[1]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
